// File: rtl/vector_reorder_pipe.sv
// Registered vector-manipulation stage: reorders, bit-selects, part-selects and popcounts a word,
// buffering results in a 2-entry FIFO behind valid/ready handshakes.
module vector_reorder_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [1:0]                   mode,
  input  logic [IDX_W-1:0]             bit_sel,
  input  logic [IDX_W-1:0]             slice_lsb,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_bit,
  output logic [SLICE_W-1:0]           out_slice,
  output logic [$clog2(WIDTH+1)-1:0]   out_pop,
  output logic [CNT_W-1:0]             xfer_cnt
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  localparam int unsigned AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SW    = (SLICE_W > 1) ? $clog2(SLICE_W) : 1;
  localparam int unsigned HALF  = WIDTH / 2;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic               sel_bit;
    logic [SLICE_W-1:0] slice;
    logic [POP_W-1:0]   pop;
  } entry_t;

  entry_t           new_entry;
  entry_t           head;
  entry_t           tail;
  entry_t           head_next;
  entry_t           tail_next;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             push;
  logic             pop;
  logic [AW-1:0]    rot_amt;
  logic [WIDTH-1:0] rev_word;
  logic [WIDTH-1:0] rot_word;
  logic [WIDTH-1:0] swp_word;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Result computation for the word currently offered by the producer.
  always_comb begin
    new_entry = '0;
    rev_word  = '0;
    rot_word  = '0;
    rot_amt   = AW'(32'(slice_lsb) % WIDTH);
    swp_word  = {in_data[HALF-1:0], in_data[WIDTH-1:HALF]};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rev_word[AW'(i)]                          = in_data[AW'(WIDTH - 1 - i)];
      rot_word[AW'((i + 32'(rot_amt)) % WIDTH)] = in_data[AW'(i)];
      new_entry.pop = new_entry.pop + POP_W'(in_data[AW'(i)]);
    end
    case (mode)
      2'd0:    new_entry.data = in_data;
      2'd1:    new_entry.data = rev_word;
      2'd2:    new_entry.data = rot_word;
      default: new_entry.data = swp_word;
    endcase
    if (32'(bit_sel) < WIDTH) new_entry.sel_bit = in_data[AW'(bit_sel)];
    // Slice bits past the MSB read as zero; no wrap-around.
    for (int unsigned j = 0; j < SLICE_W; j++) begin
      if (32'(slice_lsb) + j < WIDTH)
        new_entry.slice[SW'(j)] = in_data[AW'(32'(slice_lsb) + j)];
    end
  end

  // FIFO next-state: head is always the oldest entry, tail only used at occupancy 2.
  always_comb begin
    occ_next  = occ;
    head_next = head;
    tail_next = tail;
    if (push && !pop) begin
      if (occ == 2'd0) head_next = new_entry;
      else             tail_next = new_entry;
      occ_next = occ + 2'd1;
    end else if (!push && pop) begin
      if (occ == 2'd2) head_next = tail;
      occ_next = occ - 2'd1;
    end else if (push && pop) begin
      head_next = new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      head      <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      occ       <= occ_next;
      head      <= head_next;
      tail      <= tail_next;
      in_ready  <= (occ_next != 2'd2);
      out_valid <= (occ_next != 2'd0);
      if (push && (xfer_cnt != {CNT_W{1'b1}})) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign out_data  = head.data;
  assign out_bit   = head.sel_bit;
  assign out_slice = head.slice;
  assign out_pop   = head.pop;

endmodule
